// File: rtl/cdb_arbiter_if.sv
// Common Data Bus bundle: functional-unit requests in, one-hot grant and broadcast out.
// Latency: none (wires only).
// Backpressure: a requester holds req/tag/data until it sees its grant bit.
interface cdb_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    flush;
  logic [N_REQ-1:0]        grant;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [7:0]              busy_cnt;

  // Functional units and the flush source drive requests; they observe grant and the broadcast.
  modport master (
    output req, req_tag, req_data, flush,
    input  grant, cdb_valid, cdb_tag, cdb_data, busy_cnt
  );

  // The arbiter itself.
  modport slave (
    input  req, req_tag, req_data, flush,
    output grant, cdb_valid, cdb_tag, cdb_data, busy_cnt
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: picks one completing unit per cycle and registers its {valid,tag,data}.
// Latency: grant is combinational with req; broadcast appears one cycle after the grant.
// Backpressure: ungranted units keep requesting; flush suppresses all grants for that cycle.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input logic         clock,
  input logic         reset,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  cdb_t             cdb_q, cdb_d;
  logic [7:0]       busy_cnt_q, busy_cnt_d;

  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_vec;

  // Round-robin search starting at ptr; a grant is suppressed outright by reset or flush.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_vec   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_found && bus.req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
    if (reset || bus.flush) gnt_found = 1'b0;
    if (gnt_found) gnt_vec[gnt_idx] = 1'b1;
  end

  // Next pointer, broadcast and busy counter; flush clears pointer and valid but freezes the counter.
  always_comb begin
    ptr_d      = ptr_q;
    cdb_d      = cdb_q;
    cdb_d.valid = 1'b0;
    busy_cnt_d = busy_cnt_q;
    if (bus.flush) begin
      ptr_d = '0;
    end else begin
      if (gnt_found) begin
        ptr_d      = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        cdb_d.valid = 1'b1;
        cdb_d.tag   = bus.req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
        cdb_d.data  = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
      end
      if (($countones(bus.req) > 1) && (busy_cnt_q != 8'hFF)) begin
        busy_cnt_d = busy_cnt_q + 8'd1;
      end
    end
  end

  // State registers with immediate reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      cdb_q      <= '0;
      busy_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cdb_q      <= cdb_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.grant     = gnt_vec;
  assign bus.cdb_valid = cdb_q.valid;
  assign bus.cdb_tag   = cdb_q.tag;
  assign bus.cdb_data  = cdb_q.data;
  assign bus.busy_cnt  = busy_cnt_q;

endmodule
